// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with per-register rename tags.
// Each issued instruction reads two sources as a value or a pending ROB tag.
// It then renames its destination to the issuing tag. The file takes one
// in-order commit write per cycle and supports a global flush. Results leave
// through a one-entry registered valid/ready stage.
// Optional feature macro: RF_COMMIT_BYPASS_EN. When it is defined, a
// same-cycle commit is forwarded to matching source reads. When it is
// undefined, issue is stalled in any cycle that carries a commit.
module rename_regfile #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREG  = 32,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned RA_W  = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             iss_valid,
   output logic             iss_ready,
   input  logic [RA_W-1:0]  iss_rs1,
   input  logic [RA_W-1:0]  iss_rs2,
   input  logic [RA_W-1:0]  iss_rd,
   input  logic             iss_rd_we,
   input  logic [TAG_W-1:0] iss_tag,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [XLEN-1:0]  rd_v1,
   output logic [XLEN-1:0]  rd_v2,
   output logic             rd_b1,
   output logic             rd_b2,
   output logic [TAG_W-1:0] rd_q1,
   output logic [TAG_W-1:0] rd_q2,
   output logic [TAG_W-1:0] rd_tag,
   input  logic             cm_valid,
   input  logic [RA_W-1:0]  cm_rd,
   input  logic [TAG_W-1:0] cm_tag,
   input  logic [XLEN-1:0]  cm_data
);

   logic [XLEN-1:0]  val_q  [NREG];
   logic [XLEN-1:0]  val_d  [NREG];
   logic             busy_q [NREG];
   logic             busy_d [NREG];
   logic [TAG_W-1:0] tag_q  [NREG];
   logic [TAG_W-1:0] tag_d  [NREG];

   logic [RA_W-1:0]  src_idx [2];
   logic [XLEN-1:0]  src_v   [2];
   logic             src_b   [2];
   logic [TAG_W-1:0] src_q   [2];

   logic             out_valid_q;
   logic [XLEN-1:0]  out_v1_q, out_v2_q;
   logic             out_b1_q, out_b2_q;
   logic [TAG_W-1:0] out_q1_q, out_q2_q, out_tag_q;

   logic cm_hit;
   logic iss_fire;

   assign src_idx[0] = iss_rs1;
   assign src_idx[1] = iss_rs2;
   assign cm_hit     = cm_valid && (cm_rd != '0);

   // Issue handshake: free output slot; without forwarding, stall on commit cycles.
   always_comb begin
      iss_ready = !out_valid_q || rd_ready;
`ifndef RF_COMMIT_BYPASS_EN
      if (cm_hit) iss_ready = 1'b0;
`endif
   end

   assign iss_fire = iss_valid && iss_ready && !flush;

   // Source lookup from pre-rename state; x0 is hard-wired to value 0, not busy.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         src_v[s] = val_q[src_idx[s]];
         src_b[s] = busy_q[src_idx[s]];
         src_q[s] = tag_q[src_idx[s]];
         if (src_idx[s] == '0) begin
            src_v[s] = '0;
            src_b[s] = 1'b0;
            src_q[s] = '0;
         end
`ifdef RF_COMMIT_BYPASS_EN
         else if (cm_valid && (cm_rd == src_idx[s]) && busy_q[src_idx[s]] &&
                  (tag_q[src_idx[s]] == cm_tag)) begin
            src_v[s] = cm_data;
            src_b[s] = 1'b0;
         end
`endif
      end
   end

   // Array next state: commit first, then rename (rename wins), then flush clears busy.
   always_comb begin
      val_d  = val_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      if (cm_hit) begin
         val_d[cm_rd] = cm_data;
         if (tag_q[cm_rd] == cm_tag) busy_d[cm_rd] = 1'b0;
      end
      if (iss_fire && iss_rd_we && (iss_rd != '0)) begin
         busy_d[iss_rd] = 1'b1;
         tag_d[iss_rd]  = iss_tag;
      end
      if (flush) begin
         for (int i = 0; i < NREG; i++) busy_d[i] = 1'b0;
      end
   end

   // Register array state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            val_q[i]  <= '0;
            busy_q[i] <= 1'b0;
            tag_q[i]  <= '0;
         end
      end else begin
         val_q  <= val_d;
         busy_q <= busy_d;
         tag_q  <= tag_d;
      end
   end

   // One-entry output stage: load on fire, drain on ready, drop on flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_v1_q    <= '0;
         out_v2_q    <= '0;
         out_b1_q    <= 1'b0;
         out_b2_q    <= 1'b0;
         out_q1_q    <= '0;
         out_q2_q    <= '0;
         out_tag_q   <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (iss_fire) begin
         out_valid_q <= 1'b1;
         out_v1_q    <= src_v[0];
         out_v2_q    <= src_v[1];
         out_b1_q    <= src_b[0];
         out_b2_q    <= src_b[1];
         out_q1_q    <= src_q[0];
         out_q2_q    <= src_q[1];
         out_tag_q   <= iss_tag;
      end else if (rd_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign rd_valid = out_valid_q;
   assign rd_v1    = out_v1_q;
   assign rd_v2    = out_v2_q;
   assign rd_b1    = out_b1_q;
   assign rd_b2    = out_b2_q;
   assign rd_q1    = out_q1_q;
   assign rd_q2    = out_q2_q;
   assign rd_tag   = out_tag_q;

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: table-driven issue vectors plus
// hand-written commit, backpressure, flush, x0 and mid-run reset sequences.
// Expected outputs are queued when an issue is modelled to fire and compared
// while the output stage is modelled valid.
module tb_rename_regfile;

   logic        clk, rst, flush;
   logic        iss_valid, iss_ready;
   logic [4:0]  iss_rs1, iss_rs2, iss_rd;
   logic        iss_rd_we;
   logic [3:0]  iss_tag;
   logic        rd_valid, rd_ready;
   logic [31:0] rd_v1, rd_v2;
   logic        rd_b1, rd_b2;
   logic [3:0]  rd_q1, rd_q2, rd_tag;
   logic        cm_valid;
   logic [4:0]  cm_rd;
   logic [3:0]  cm_tag;
   logic [31:0] cm_data;

   typedef struct packed {
      logic [31:0] v1;
      logic        b1;
      logic [3:0]  q1;
      logic [31:0] v2;
      logic        b2;
      logic [3:0]  q2;
      logic [3:0]  tag;
   } out_t;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       we;
      logic [3:0] tag;
      out_t       exp;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   logic m_valid = 1'b0;
   out_t exp_q[$];
   vec_t vt [10];

   rename_regfile dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .iss_valid (iss_valid),
      .iss_ready (iss_ready),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_rd    (iss_rd),
      .iss_rd_we (iss_rd_we),
      .iss_tag   (iss_tag),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_v1     (rd_v1),
      .rd_v2     (rd_v2),
      .rd_b1     (rd_b1),
      .rd_b2     (rd_b2),
      .rd_q1     (rd_q1),
      .rd_q2     (rd_q2),
      .rd_tag    (rd_tag),
      .cm_valid  (cm_valid),
      .cm_rd     (cm_rd),
      .cm_tag    (cm_tag),
      .cm_data   (cm_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic out_t ox(input logic [31:0] v1, input logic b1, input logic [3:0] q1,
                               input logic [31:0] v2, input logic b2, input logic [3:0] q2,
                               input logic [3:0] t);
      out_t o;
      o.v1 = v1; o.b1 = b1; o.q1 = q1;
      o.v2 = v2; o.b2 = b2; o.q2 = q2;
      o.tag = t;
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Value fields are only meaningful when not busy; tag fields only when busy.
   task automatic cmp_out(input out_t e);
      chk("rd_tag", rd_tag, e.tag);
      chk("rd_b1", rd_b1, e.b1);
      chk("rd_b2", rd_b2, e.b2);
      if (e.b1) chk("rd_q1", rd_q1, e.q1);
      else      chk("rd_v1", rd_v1, e.v1);
      if (e.b2) chk("rd_q2", rd_q2, e.q2);
      else      chk("rd_v2", rd_v2, e.v2);
   endtask

   task automatic set_iss(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                          input logic w, input logic [3:0] t);
      iss_valid = 1'b1;
      iss_rs1   = a;
      iss_rs2   = b;
      iss_rd    = d;
      iss_rd_we = w;
      iss_tag   = t;
   endtask

   // One clock: check handshake/output mid-cycle, then advance the output model.
   task automatic tick(input out_t e);
      logic er, fire;
      @(negedge clk);
      er = !m_valid || rd_ready;
`ifndef RF_COMMIT_BYPASS_EN
      if (cm_valid && cm_rd != 5'd0) er = 1'b0;
`endif
      chk("iss_ready", iss_ready, er);
      chk("rd_valid", rd_valid, m_valid);
      if (m_valid && exp_q.size() > 0) cmp_out(exp_q[0]);
      fire = iss_valid && er && !flush;
      @(posedge clk);
      if (flush) begin
         m_valid = 1'b0;
         exp_q.delete();
      end else begin
         if (m_valid && rd_ready) begin
            void'(exp_q.pop_front());
            m_valid = 1'b0;
         end
         if (fire) begin
            exp_q.push_back(e);
            m_valid = 1'b1;
         end
      end
      #1;
   endtask

   initial begin
      out_t e1, e2;
      rst = 1'b1; flush = 1'b0; iss_valid = 1'b0;
      iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_rd_we = 1'b0; iss_tag = '0;
      rd_ready = 1'b1; cm_valid = 1'b0; cm_rd = '0; cm_tag = '0; cm_data = '0;

      vt[0] = '{5'd5,  5'd0,  5'd5,  1'b1, 4'd3, ox(0, 0, 0, 0, 0, 0, 4'd3)};
      vt[1] = '{5'd5,  5'd5,  5'd6,  1'b1, 4'd4, ox(0, 1, 3, 0, 1, 3, 4'd4)};
      vt[2] = '{5'd6,  5'd0,  5'd7,  1'b1, 4'd1, ox(0, 1, 4, 0, 0, 0, 4'd1)};
      vt[3] = '{5'd7,  5'd6,  5'd7,  1'b1, 4'd2, ox(0, 1, 1, 0, 1, 4, 4'd2)};
      vt[4] = '{5'd7,  5'd0,  5'd0,  1'b1, 4'd5, ox(0, 1, 2, 0, 0, 0, 4'd5)};
      vt[5] = '{5'd0,  5'd0,  5'd8,  1'b1, 4'd2, ox(0, 0, 0, 0, 0, 0, 4'd2)};
      vt[6] = '{5'd8,  5'd9,  5'd9,  1'b1, 4'd6, ox(0, 1, 2, 0, 0, 0, 4'd6)};
      vt[7] = '{5'd10, 5'd11, 5'd10, 1'b1, 4'd7, ox(0, 0, 0, 0, 0, 0, 4'd7)};
      vt[8] = '{5'd9,  5'd10, 5'd11, 1'b0, 4'd8, ox(0, 1, 6, 0, 1, 7, 4'd8)};
      vt[9] = '{5'd11, 5'd0,  5'd0,  1'b0, 4'd9, ox(0, 0, 0, 0, 0, 0, 4'd9)};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset rd_v1", rd_v1, 32'd0);
      chk("reset rd_tag", rd_tag, 32'd0);
      chk("reset rd_b1", rd_b1, 32'd0);
      tick('0);

      // Back-to-back issues at full throughput, including dependent renames.
      for (int i = 0; i < 10; i++) begin
         set_iss(vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].we, vt[i].tag);
         tick(vt[i].exp);
      end
      iss_valid = 1'b0;
      tick('0);

      // Matching commit clears busy and writes the value.
      cm_valid = 1'b1; cm_rd = 5'd5; cm_tag = 4'd3; cm_data = 32'hDEAD;
      tick('0);
      cm_valid = 1'b0;
      set_iss(5'd5, 5'd6, 5'd0, 1'b0, 4'd10);
      tick(ox(32'hDEAD, 0, 0, 0, 1, 4, 4'd10));
      iss_valid = 1'b0;
      tick('0);

      // Stale commit writes the value but the newer rename survives.
      cm_valid = 1'b1; cm_rd = 5'd7; cm_tag = 4'd1; cm_data = 32'd9;
      tick('0);
      cm_valid = 1'b0;
      set_iss(5'd7, 5'd0, 5'd0, 1'b0, 4'd11);
      tick(ox(0, 1, 2, 0, 0, 0, 4'd11));
      iss_valid = 1'b0;
      tick('0);

      // Same-cycle commit and dependent read.
      e1 = ox(32'h55, 0, 0, 0, 0, 0, 4'd12);
      cm_valid = 1'b1; cm_rd = 5'd8; cm_tag = 4'd2; cm_data = 32'h55;
      set_iss(5'd8, 5'd0, 5'd0, 1'b0, 4'd12);
      tick(e1);
      cm_valid = 1'b0;
`ifndef RF_COMMIT_BYPASS_EN
      tick(e1);
`endif
      iss_valid = 1'b0;
      tick('0);

      // Backpressure: output holds for 3 cycles, then one transfer.
      rd_ready = 1'b0;
      set_iss(5'd9, 5'd10, 5'd0, 1'b0, 4'd12);
      tick(ox(0, 1, 6, 0, 1, 7, 4'd12));
      e2 = ox(32'hDEAD, 0, 0, 0, 0, 0, 4'd13);
      set_iss(5'd5, 5'd0, 5'd0, 1'b0, 4'd13);
      repeat (3) tick(e2);
      rd_ready = 1'b1;
      tick(e2);
      iss_valid = 1'b0;
      tick('0);

      // Flush with a pending output and a same-cycle commit.
      rd_ready = 1'b0;
      set_iss(5'd10, 5'd0, 5'd0, 1'b0, 4'd14);
      tick(ox(0, 1, 7, 0, 0, 0, 4'd14));
      set_iss(5'd1, 5'd2, 5'd1, 1'b1, 4'd15);
      flush = 1'b1;
      cm_valid = 1'b1; cm_rd = 5'd9; cm_tag = 4'd6; cm_data = 32'd7;
      tick('0);
      // A second flush cycle with the slot free: the x1 rename must not land.
      cm_valid = 1'b0; rd_ready = 1'b1;
      tick('0);
      flush = 1'b0;
      set_iss(5'd9, 5'd10, 5'd0, 1'b0, 4'd0);
      tick(ox(32'd7, 0, 0, 0, 0, 0, 4'd0));
      set_iss(5'd7, 5'd8, 5'd0, 1'b0, 4'd1);
      tick(ox(32'd9, 0, 0, 32'h55, 0, 0, 4'd1));
      set_iss(5'd1, 5'd6, 5'd0, 1'b0, 4'd2);
      tick(ox(0, 0, 0, 0, 0, 0, 4'd2));

      // x0: commit and rename are ignored, reads return 0.
      cm_valid = 1'b1; cm_rd = 5'd0; cm_tag = 4'd0; cm_data = 32'hFFFF;
      set_iss(5'd3, 5'd0, 5'd0, 1'b1, 4'd9);
      tick(ox(0, 0, 0, 0, 0, 0, 4'd9));
      cm_valid = 1'b0;
      set_iss(5'd0, 5'd0, 5'd2, 1'b0, 4'd1);
      tick(ox(0, 0, 0, 0, 0, 0, 4'd1));
      iss_valid = 1'b0;
      tick('0);

      // Reset mid-operation drops the pending output and clears the arrays.
      rd_ready = 1'b0;
      set_iss(5'd6, 5'd0, 5'd0, 1'b0, 4'd5);
      tick(ox(0, 0, 0, 0, 0, 0, 4'd5));
      rst = 1'b1;
      iss_valid = 1'b0;
      #2;
      chk("midrst rd_valid", rd_valid, 32'd0);
      chk("midrst rd_tag", rd_tag, 32'd0);
      m_valid = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      rd_ready = 1'b1;
      set_iss(5'd5, 5'd9, 5'd0, 1'b0, 4'd3);
      tick(ox(0, 0, 0, 0, 0, 0, 4'd3));
      iss_valid = 1'b0;
      tick('0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rename_regfile.md
# rename_regfile

Parametrised architectural register file with per-register rename tags for the out-of-order core. It sits between the decoder and the ROB. On each issued instruction it reads both source operands as either a value or a pending ROB tag, then renames the destination to the issuing ROB tag. It accepts one in-order commit write per cycle, supports a global flush, and presents results through a one-entry registered valid/ready stage.

## Interface
- `XLEN`, 32, data width.
- `NREG`, 32, number of architectural registers, including x0.
- `TAG_W`, 4, ROB tag width.
- `RA_W`, `$clog2(NREG)`, register-index width (derived).

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: ROB misprediction/exception; discards all speculative renames.
- `iss_valid` in 1 / `iss_ready` out 1: issue handshake from the decoder.
- `iss_rs1`, `iss_rs2` in RA_W: source register indices.
- `iss_rd` in RA_W: destination register index.
- `iss_rd_we` in 1: instruction writes `rd`.
- `iss_tag` in TAG_W: ROB tag allocated to this instruction.
- `rd_valid` out 1 / `rd_ready` in 1: output handshake to the ROB.
- `rd_v1`, `rd_v2` out XLEN: operand values, meaningful when the matching busy flag is 0.
- `rd_b1`, `rd_b2` out 1: operand pending.
- `rd_q1`, `rd_q2` out TAG_W: producer tag, meaningful when the matching busy flag is 1.
- `rd_tag` out TAG_W: registered copy of `iss_tag`.
- `cm_valid` in 1: commit strobe.
- `cm_rd` in RA_W: commit destination register.
- `cm_tag` in TAG_W: tag of the committing instruction.
- `cm_data` in XLEN: committed value.

## Operation
- State per register: `val[XLEN]`, `busy`, `tag[TAG_W]`.
- x0 rules:
  - Always reads value 0, busy 0.
  - Never written and never renamed.
- Issue fires when `iss_valid && iss_ready && !flush`. On fire:
  - Sources are read from the pre-rename state. If `rs == rd` in the same instruction, the source sees the old mapping.
  - The output stage loads the source results and `rd_tag`.
  - If `iss_rd_we && iss_rd != 0`: set `busy[rd] = 1` and `tag[rd] = iss_tag`.
- Commit applies when `cm_valid && cm_rd != 0`:
  - `val[cm_rd] = cm_data` unconditionally.
  - `busy[cm_rd]` is cleared only if `tag[cm_rd] == cm_tag`; a newer rename survives.
  - Same-cycle issue renaming the same `rd`: the rename wins (busy stays 1, tag = `iss_tag`). The value is still written.
- Flush:
  - Clears every `busy` and clears `rd_valid`.
  - No issue fires in the flush cycle.
  - A commit in the same cycle is still applied, so committed state is never lost.
  - `tag[]` contents are left stale; they are don't-care while busy = 0.
- Output stage:
  - `iss_ready = !rd_valid || rd_ready`, additionally gated by the configuration rule below.
  - While `rd_valid && !rd_ready`, all `rd_*` outputs hold stable.

## Timing
- Reset values:
  - All `val`, `busy`, `tag` = 0.
  - `rd_valid` = 0.
  - All `rd_*` data outputs = 0.
  - `iss_ready` = 1 once `rst` is released, subject to the configuration rule.
- Latency: issue fire in cycle N gives `rd_valid` = 1 in cycle N+1, with operands sampled in cycle N.
- A commit in cycle N is visible in array reads from cycle N+1.
- Full throughput: one issue per cycle when `rd_ready` is held at 1.
- Back-to-back dependent issues: a rename in cycle N is seen by sources read in cycle N+1.
- Reset mid-operation clears everything immediately, including an un-accepted output.

## Configuration
- `RF_COMMIT_BYPASS_EN` defined:
  - A source read whose register matches a same-cycle commit (`cm_valid`, `cm_rd == rs != 0`, `busy`, `tag == cm_tag`) returns `cm_data` with busy 0.
  - `iss_ready` is not affected by commits.
- `RF_COMMIT_BYPASS_EN` undefined:
  - No forwarding.
  - `iss_ready` is forced to 0 in any cycle with `cm_valid && cm_rd != 0`. This guarantees no operand can miss its producer's broadcast.

## Test plan
- Reset, then issue `rs1=5, rs2=0, rd=5, we=1, tag=3` -> next cycle: `rd_v1=0`, `rd_b1=0`, `rd_b2=0`; `busy[5]=1`, `tag[5]=3`.
- Then issue `rs1=5, rd=6, tag=4` -> `rd_b1=1`, `rd_q1=3`. Commit `rd=5, tag=3, data=0xDEAD` -> a later read of x5 returns `0xDEAD`, busy 0.
- Rename x7 to tag 1, then to tag 2; commit `rd=7, tag=1, data=9` -> `val[7]=9`, `busy[7]` stays 1 with `tag=2`.
- Same-cycle commit `rd=8, tag=2, data=0x55` and issue with `rs1=8`:
  - With the macro: `rd_v1=0x55`, `rd_b1=0`.
  - Without the macro: `iss_ready=0` that cycle; next cycle the issue fires and `rd_v1=0x55`.
- Hold `rd_ready=0` for 3 cycles with a pending output -> `rd_*` stable and `iss_ready=0`; release -> one transfer, then the next issue is accepted.
- Flush together with commit `rd=9, data=7` while x9 and x10 are busy -> all busy cleared, `val[9]=7`, `rd_valid=0`. Writes to x0 are ignored and x0 always reads 0.
